// File: rtl/riscv_tag_check_unit.sv
// riscv_tag_check_unit
//
// Registered DIFT tag check stage. For each EX instruction it applies the
// per-class S1/S2/D policy from tcr_i under tag_mask_i. A hit raises a held
// exception request, stalls EX until the controller acknowledges, and records
// the violation for the CSR block.
//
// Optional feature macro: RISCV_TAG_CHECK_PC_EN
//   Adds tag_pc_i and the EXECUTE_PC policy bit tcr_i[3*N_CLASSES].
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   check_valid_i     EX instruction valid for checking
//   check_class_i     class index of the EX instruction
//   tag_s1_i/s2/d     operand tags (rs1, rs2/store data, rd/address)
//   tag_pc_i          PC tag (RISCV_TAG_CHECK_PC_EN only)
//   pc_i              EX instruction PC
//   tcr_i             policy: 3 enables per class, then EXECUTE_PC
//   tag_mask_i        tag bits that count as tainted
//   clear_i           clear violation status and counter
//   exc_ack_i         exception acknowledged by the controller
//   exc_req_o         tag exception request (held until ack)
//   stall_o           hold EX stage while the request is pending
//   viol_pc_o         PC of last violation
//   viol_class_o      class of last violation
//   viol_src_o        offending operands: [0] S1, [1] S2, [2] D, [3] PC
//   viol_cnt_o        saturating violation count

module riscv_tag_check_unit #(
   parameter int unsigned TAG_WIDTH = 1,
   parameter int unsigned N_CLASSES = 8,
   parameter int unsigned CNT_WIDTH = 16,
   localparam int unsigned CLASS_W = $clog2(N_CLASSES)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   check_valid_i,
   input  logic [CLASS_W-1:0]     check_class_i,
   input  logic [TAG_WIDTH-1:0]   tag_s1_i,
   input  logic [TAG_WIDTH-1:0]   tag_s2_i,
   input  logic [TAG_WIDTH-1:0]   tag_d_i,
`ifdef RISCV_TAG_CHECK_PC_EN
   input  logic [TAG_WIDTH-1:0]   tag_pc_i,
`endif
   input  logic [31:0]            pc_i,
   input  logic [3*N_CLASSES:0]   tcr_i,
   input  logic [TAG_WIDTH-1:0]   tag_mask_i,
   input  logic                   clear_i,
   input  logic                   exc_ack_i,
   output logic                   exc_req_o,
   output logic                   stall_o,
   output logic [31:0]            viol_pc_o,
   output logic [CLASS_W-1:0]     viol_class_o,
   output logic [3:0]             viol_src_o,
   output logic [CNT_WIDTH-1:0]   viol_cnt_o
);

   typedef enum logic [0:0] {StIdle, StReq} state_e;

   state_e                 state_q, state_d;
   logic [31:0]            pc_q, pc_d;
   logic [CLASS_W-1:0]     class_q, class_d;
   logic [3:0]             src_q, src_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

   logic [3:0]             hit_src;
   logic                   hit;

   // Per-operand hit vector. Out-of-range classes match no loop iteration,
   // so only the PC check can fire for them.
   always_comb begin
      hit_src = 4'b0000;
      for (int unsigned k = 0; k < N_CLASSES; k++) begin
         if (check_class_i == CLASS_W'(k)) begin
            hit_src[0] = tcr_i[3*k]     & (|(tag_s1_i & tag_mask_i));
            hit_src[1] = tcr_i[3*k + 1] & (|(tag_s2_i & tag_mask_i));
            hit_src[2] = tcr_i[3*k + 2] & (|(tag_d_i  & tag_mask_i));
         end
      end
`ifdef RISCV_TAG_CHECK_PC_EN
      hit_src[3] = tcr_i[3*N_CLASSES] & (|(tag_pc_i & tag_mask_i));
`endif
   end

`ifndef RISCV_TAG_CHECK_PC_EN
   // EXECUTE_PC policy bit has no effect without the PC tag input.
   logic unused_tcr_pc;
   assign unused_tcr_pc = tcr_i[3*N_CLASSES];
`endif

   assign hit = check_valid_i & (|hit_src);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      class_d = class_q;
      src_d   = src_q;
      cnt_d   = cnt_q;

      // Clear first so a same-cycle capture below takes precedence.
      if (clear_i) begin
         pc_d    = '0;
         class_d = '0;
         src_d   = '0;
         cnt_d   = '0;
      end

      case (state_q)
         StIdle: begin
            if (hit) begin
               state_d = StReq;
               pc_d    = pc_i;
               class_d = check_class_i;
               src_d   = hit_src;
               if (clear_i) begin
                  cnt_d = CNT_WIDTH'(1);
               end else if (cnt_q != {CNT_WIDTH{1'b1}}) begin
                  cnt_d = cnt_q + CNT_WIDTH'(1);
               end
            end
         end
         StReq: begin
            // New instructions are frozen by stall_o; only the ack matters here.
            if (exc_ack_i) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         pc_q    <= '0;
         class_q <= '0;
         src_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         class_q <= class_d;
         src_q   <= src_d;
         cnt_q   <= cnt_d;
      end
   end

   // Both handshake outputs come straight from the state flop.
   assign exc_req_o    = (state_q == StReq);
   assign stall_o      = (state_q == StReq);
   assign viol_pc_o    = pc_q;
   assign viol_class_o = class_q;
   assign viol_src_o   = src_q;
   assign viol_cnt_o   = cnt_q;

endmodule

// File: tb/tb_riscv_tag_check_unit.sv
module tb_riscv_tag_check_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [2:0]  cls;
   logic        s1, s2, d, tpc;
   logic [31:0] pc;
   logic [24:0] tcr;
   logic        mask;
   logic        clear;
   logic        ack;

   // Main DUT (defaults)
   logic        exc_req, stall;
   logic [31:0] viol_pc;
   logic [2:0]  viol_class;
   logic [3:0]  viol_src;
   logic [15:0] viol_cnt;
   // CNT_WIDTH = 2 instance
   logic        req2, stall2;
   logic [31:0] pc2;
   logic [2:0]  class2;
   logic [3:0]  src2;
   logic [1:0]  cnt2;
   // N_CLASSES = 7 instance
   logic        req3, stall3;
   logic [31:0] pc3;
   logic [2:0]  class3;
   logic [3:0]  src3;
   logic [15:0] cnt3;

   int total = 0;
   int bad   = 0;

   logic [56:0] sb_q[$];
   logic [56:0] obs, exp_v;
   assign obs = {exc_req, stall, viol_pc, viol_class, viol_src, viol_cnt};

   // Reference model state
   logic        m_req;
   logic [31:0] m_pc;
   logic [2:0]  m_cls;
   logic [3:0]  m_src;
   logic [15:0] m_cnt;

   always #5 clk = ~clk;

   riscv_tag_check_unit dut (
      .clk(clk), .rst(rst), .check_valid_i(valid), .check_class_i(cls),
      .tag_s1_i(s1), .tag_s2_i(s2), .tag_d_i(d),
`ifdef RISCV_TAG_CHECK_PC_EN
      .tag_pc_i(tpc),
`endif
      .pc_i(pc), .tcr_i(tcr), .tag_mask_i(mask), .clear_i(clear), .exc_ack_i(ack),
      .exc_req_o(exc_req), .stall_o(stall), .viol_pc_o(viol_pc),
      .viol_class_o(viol_class), .viol_src_o(viol_src), .viol_cnt_o(viol_cnt)
   );

   riscv_tag_check_unit #(.CNT_WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .check_valid_i(valid), .check_class_i(cls),
      .tag_s1_i(s1), .tag_s2_i(s2), .tag_d_i(d),
`ifdef RISCV_TAG_CHECK_PC_EN
      .tag_pc_i(tpc),
`endif
      .pc_i(pc), .tcr_i(tcr), .tag_mask_i(mask), .clear_i(clear), .exc_ack_i(ack),
      .exc_req_o(req2), .stall_o(stall2), .viol_pc_o(pc2),
      .viol_class_o(class2), .viol_src_o(src2), .viol_cnt_o(cnt2)
   );

   riscv_tag_check_unit #(.N_CLASSES(7)) dut3 (
      .clk(clk), .rst(rst), .check_valid_i(valid), .check_class_i(cls),
      .tag_s1_i(s1), .tag_s2_i(s2), .tag_d_i(d),
`ifdef RISCV_TAG_CHECK_PC_EN
      .tag_pc_i(tpc),
`endif
      .pc_i(pc), .tcr_i(tcr[21:0]), .tag_mask_i(mask), .clear_i(clear), .exc_ack_i(ack),
      .exc_req_o(req3), .stall_o(stall3), .viol_pc_o(pc3),
      .viol_class_o(class3), .viol_src_o(src3), .viol_cnt_o(cnt3)
   );

   // Advance the model on the currently driven inputs, push the expected
   // main-DUT outputs, then clock and settle.
   task automatic step();
      logic [3:0] hs;
      logic       hit;
      int         c;
      c  = int'(cls);
      hs = 4'b0000;
      hs[0] = tcr[3*c]     & (s1 & mask);
      hs[1] = tcr[3*c + 1] & (s2 & mask);
      hs[2] = tcr[3*c + 2] & (d  & mask);
`ifdef RISCV_TAG_CHECK_PC_EN
      hs[3] = tcr[24] & (tpc & mask);
`endif
      hit = valid & (|hs);
      if (rst) begin
         m_req = 1'b0; m_pc = '0; m_cls = '0; m_src = '0; m_cnt = '0;
      end else if (!m_req) begin
         if (hit) begin
            m_req = 1'b1; m_pc = pc; m_cls = cls; m_src = hs;
            if (clear) m_cnt = 16'd1;
            else if (m_cnt != 16'hffff) m_cnt = m_cnt + 16'd1;
         end else if (clear) begin
            m_pc = '0; m_cls = '0; m_src = '0; m_cnt = '0;
         end
      end else begin
         if (clear) begin
            m_pc = '0; m_cls = '0; m_src = '0; m_cnt = '0;
         end
         if (ack) m_req = 1'b0;
      end
      sb_q.push_back({m_req, m_req, m_pc, m_cls, m_src, m_cnt});
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      valid = 0; cls = 0; s1 = 0; s2 = 0; d = 0; tpc = 0; pc = 0;
      tcr = 0; mask = 0; clear = 0; ack = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      step();
      exp_v = sb_q.pop_front();
      total++;
      if (obs !== exp_v || obs !== 57'd0) begin
         bad++; $display("FAIL reset: got=%h want=%h", obs, exp_v);
      end
      total++;
      if ({req2, cnt2, req3, cnt3} !== 19'd0) begin
         bad++; $display("FAIL reset_aux: got=%h want=0", {req2, cnt2, req3, cnt3});
      end
      rst = 0;
   endtask

   task automatic test_basic_hit();
      valid = 1; cls = 3; tcr = 25'd1 << 9; s1 = 1; mask = 1; pc = 32'h100;
      step();
      exp_v = sb_q.pop_front();
      total++;
      if (obs !== exp_v || obs !== {1'b1, 1'b1, 32'h100, 3'd3, 4'b0001, 16'd1}) begin
         bad++; $display("FAIL basic_hit: got=%h want=%h", obs, exp_v);
      end
      valid = 0; ack = 1;
      step();
      exp_v = sb_q.pop_front();
      total++;
      if (obs !== exp_v) begin
         bad++; $display("FAIL basic_ack: got=%h want=%h", obs, exp_v);
      end
      idle_inputs();
   endtask

   task automatic test_no_hit();
      rst = 1; step(); void'(sb_q.pop_front()); rst = 0;
      valid = 1; cls = 3; tcr = 25'd1 << 9; s1 = 1; mask = 0; pc = 32'h100;
      step();
      exp_v = sb_q.pop_front();
      total++;
      if (obs !== exp_v || exc_req !== 1'b0 || viol_cnt !== 16'd0) begin
         bad++; $display("FAIL mask_zero: got=%h want=%h", obs, exp_v);
      end
      // Class 7 is out of range for the 7-class instance only.
      cls = 7; tcr = 25'd1 << 21; mask = 1;
      step();
      exp_v = sb_q.pop_front();
      total++;
      if (obs !== exp_v) begin
         bad++; $display("FAIL class7_main: got=%h want=%h", obs, exp_v);
      end
      total++;
      if (req3 !== 1'b0 || cnt3 !== 16'd0) begin
         bad++; $display("FAIL class_oob: got req=%0b cnt=%0d want req=0 cnt=0", req3, cnt3);
      end
      valid = 0; ack = 1;
      step(); void'(sb_q.pop_front());
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      rst = 1; step(); void'(sb_q.pop_front()); rst = 0;
      valid = 1; cls = 3; tcr = (25'd1 << 9) | (25'd1 << 8); s1 = 1; d = 1; mask = 1;
      pc = 32'h200;
      step();
      exp_v = sb_q.pop_front();
      total++;
      if (obs !== exp_v) begin
         bad++; $display("FAIL b2b_first: got=%h want=%h", obs, exp_v);
      end
      for (int i = 0; i < 5; i++) begin
         cls = 2; pc = 32'h300 + i;
         step();
         exp_v = sb_q.pop_front();
         total++;
         if (obs !== exp_v) begin
            bad++; $display("FAIL b2b_hold%0d: got=%h want=%h", i, obs, exp_v);
         end
      end
      ack = 1; cls = 3; pc = 32'h400;
      step();
      exp_v = sb_q.pop_front();
      total++;
      if (obs !== exp_v || exc_req !== 1'b0 || stall !== 1'b0) begin
         bad++; $display("FAIL b2b_ack: got=%h want=%h", obs, exp_v);
      end
      ack = 0;
      step();
      exp_v = sb_q.pop_front();
      total++;
      if (obs !== exp_v || exc_req !== 1'b1 || viol_cnt !== 16'd2) begin
         bad++; $display("FAIL b2b_reenter: got=%h want=%h", obs, exp_v);
      end
      valid = 0; ack = 1;
      step(); void'(sb_q.pop_front());
      idle_inputs();
   endtask

   task automatic test_clear_in_req();
      valid = 1; cls = 5; tcr = 25'd1 << 16; s2 = 1; mask = 1; pc = 32'h600;
      step(); void'(sb_q.pop_front());
      valid = 0; clear = 1;
      step();
      exp_v = sb_q.pop_front();
      total++;
      if (obs !== exp_v || obs !== {1'b1, 1'b1, 55'd0}) begin
         bad++; $display("FAIL clear_in_req: got=%h want=%h", obs, exp_v);
      end
      clear = 0; ack = 1;
      step(); void'(sb_q.pop_front());
      idle_inputs();
   endtask

   task automatic test_saturation();
      logic [1:0] want;
      rst = 1; step(); void'(sb_q.pop_front()); rst = 0;
      for (int i = 0; i < 4; i++) begin
         valid = 1; cls = 3; tcr = 25'd1 << 9; s1 = 1; mask = 1; pc = 32'h700 + i;
         step();
         exp_v = sb_q.pop_front();
         total++;
         if (obs !== exp_v) begin
            bad++; $display("FAIL sat_main%0d: got=%h want=%h", i, obs, exp_v);
         end
         want = (i < 3) ? 2'(i + 1) : 2'd3;
         total++;
         if (cnt2 !== want || req2 !== 1'b1) begin
            bad++; $display("FAIL sat_cnt%0d: got=%0d want=%0d", i, cnt2, want);
         end
         valid = 0; ack = 1;
         step(); void'(sb_q.pop_front());
         ack = 0;
      end
      valid = 1; clear = 1;
      step();
      exp_v = sb_q.pop_front();
      total++;
      if (obs !== exp_v) begin
         bad++; $display("FAIL sat_clear_main: got=%h want=%h", obs, exp_v);
      end
      total++;
      if (cnt2 !== 2'd1) begin
         bad++; $display("FAIL sat_clear_cnt: got=%0d want=1", cnt2);
      end
      valid = 0; clear = 0; ack = 1;
      step(); void'(sb_q.pop_front());
      idle_inputs();
   endtask

   task automatic test_reset_mid_req();
      valid = 1; cls = 3; tcr = 25'd1 << 9; s1 = 1; mask = 1; pc = 32'h800;
      step(); void'(sb_q.pop_front());
      rst = 1;
      step();
      exp_v = sb_q.pop_front();
      total++;
      if (obs !== exp_v || obs !== 57'd0) begin
         bad++; $display("FAIL reset_mid_req: got=%h want=%h", obs, exp_v);
      end
      rst = 0;
      step();
      exp_v = sb_q.pop_front();
      total++;
      if (obs !== exp_v || exc_req !== 1'b1 || viol_cnt !== 16'd1) begin
         bad++; $display("FAIL post_reset_hit: got=%h want=%h", obs, exp_v);
      end
      valid = 0; ack = 1;
      step(); void'(sb_q.pop_front());
      idle_inputs();
   endtask

   task automatic test_pc_tag();
      logic want_req;
      rst = 1; step(); void'(sb_q.pop_front()); rst = 0;
      valid = 1; cls = 2; tcr = 25'd1 << 24; s1 = 1; s2 = 1; d = 1; tpc = 1; mask = 1;
      pc = 32'h900;
      step();
      exp_v = sb_q.pop_front();
`ifdef RISCV_TAG_CHECK_PC_EN
      want_req = 1'b1;
`else
      want_req = 1'b0;
`endif
      total++;
      if (obs !== exp_v || exc_req !== want_req ||
          viol_src !== (want_req ? 4'b1000 : 4'b0000)) begin
         bad++; $display("FAIL pc_tag: got=%h want=%h", obs, exp_v);
      end
      valid = 0; ack = 1;
      step(); void'(sb_q.pop_front());
      idle_inputs();
   endtask

   task automatic test_random();
      for (int i = 0; i < 80; i++) begin
         valid = 1'($urandom);
         cls   = 3'($urandom);
         s1    = 1'($urandom);
         s2    = 1'($urandom);
         d     = 1'($urandom);
         tpc   = 1'($urandom);
         tcr   = 25'($urandom);
         mask  = ($urandom_range(0, 3) != 0);
         pc    = $urandom;
         ack   = 1'($urandom);
         clear = ($urandom_range(0, 7) == 0);
         step();
         exp_v = sb_q.pop_front();
         total++;
         if (obs !== exp_v) begin
            bad++; $display("FAIL random%0d: got=%h want=%h", i, obs, exp_v);
         end
      end
      idle_inputs();
   endtask

   initial begin
      m_req = 0; m_pc = 0; m_cls = 0; m_src = 0; m_cnt = 0;
      rst = 1;
      idle_inputs();
      test_reset();
      test_basic_hit();
      test_no_hit();
      test_back_to_back();
      test_clear_in_req();
      test_saturation();
      test_reset_mid_req();
      test_pc_tag();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/riscv_tag_check_unit.md
Name: riscv_tag_check_unit

Overview:
- Parametrised, registered successor to the combinational DIFT check decoder.
- Takes a decoded instruction class and operand tags from the EX stage, applies a per-class S1/S2/D check policy under a tag-bit mask, and registers any violation.
- Raises a held exception request with a req/ack handshake, stalls the pipeline while the request is pending, and keeps violation status and a saturating counter for the CSR block.

Parameters:
TAG_WIDTH, 1, bits per tag
N_CLASSES, 8, number of check classes (0 jump, 1 branch, 2 load/store, 3 integer, 4 shift, 5 comparison, 6 logical, 7 reserved)
CNT_WIDTH, 16, violation counter width
CLASS_W, $clog2(N_CLASSES), class index width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
check_valid_i  in  1  EX instruction valid for checking
check_class_i  in  CLASS_W  class index of EX instruction
tag_s1_i  in  TAG_WIDTH  rs1 tag
tag_s2_i  in  TAG_WIDTH  rs2 / store-data tag
tag_d_i  in  TAG_WIDTH  rd / address tag
pc_i  in  32  EX instruction PC
tcr_i  in  3*N_CLASSES+1  policy: bit 3k = S1 enable, bit 3k+1 = S2 enable, bit 3k+2 = D enable for class k; bit 3*N_CLASSES = EXECUTE_PC
tag_mask_i  in  TAG_WIDTH  tag bits that count as tainted
clear_i  in  1  clear status and counter
exc_ack_i  in  1  exception acknowledged by controller
exc_req_o  out  1  tag exception request
stall_o  out  1  hold EX stage
viol_pc_o  out  32  PC of last violation
viol_class_o  out  CLASS_W  class of last violation
viol_src_o  out  4  offending operands of last violation: [0] S1, [1] S2, [2] D, [3] PC
viol_cnt_o  out  CNT_WIDTH  saturating violation count

Behaviour:
- Hit condition, combinational:
  - hit_s1 = tcr[3c] & |(tag_s1_i & tag_mask_i); hit_s2 and hit_d likewise using bits 3c+1 and 3c+2.
  - hit = check_valid_i & (hit_s1 | hit_s2 | hit_d), where c = check_class_i.
  - check_class_i >= N_CLASSES: no hit.
- FSM states: IDLE, REQ.
  - IDLE: a hit at cycle N moves to REQ at N+1 and captures viol_pc_o, viol_class_o and viol_src_o from the cycle-N inputs.
  - IDLE: viol_cnt_o increments by 1 at N+1 and saturates at all-ones.
  - REQ: exc_req_o = 1 and stall_o = 1. check_valid_i and all operand inputs are ignored.
  - REQ: exc_ack_i = 1 at cycle M returns to IDLE at M+1; exc_req_o and stall_o are low at M+1.
  - exc_ack_i is sampled only in REQ.
  - A hit presented in IDLE at M+1 is processed normally: back-to-back violations re-enter REQ at M+2.
- Latency: violation to exc_req_o is exactly 1 cycle. No combinational path from any input to exc_req_o or stall_o.
- clear_i:
  - Zeros viol_cnt_o, viol_pc_o, viol_class_o and viol_src_o next cycle.
  - Does not leave REQ and does not drop exc_req_o.
  - clear_i in the same cycle as an IDLE hit: the new capture wins and viol_cnt_o = 1.
- Reset (any cycle, including mid-REQ):
  - State IDLE; all outputs 0 next cycle.
  - A pending request is dropped without ack.
- tcr_i and tag_mask_i are sampled live each cycle; changing them while in REQ has no effect on the pending request.

Optional Feature:
RISCV_TAG_CHECK_PC_EN:
- Defined:
  - Adds port tag_pc_i (in, TAG_WIDTH).
  - hit_pc = tcr[3*N_CLASSES] & |(tag_pc_i & tag_mask_i), ORed into hit for any valid instruction, any class including out-of-range.
  - viol_src_o[3] captures hit_pc.
- Undefined:
  - No tag_pc_i port.
  - tcr bit 3*N_CLASSES is ignored.
  - viol_src_o[3] is constant 0.

Test Plan:
- Reset, then check_valid_i = 1, class 3, tcr bit 9 = 1, tag_s1_i = 1, mask = 1, pc_i = 0x100 -> next cycle: exc_req_o = 1, stall_o = 1, viol_pc_o = 0x100, viol_class_o = 3, viol_src_o = 4'b0001, viol_cnt_o = 1.
- Same stimulus with mask = 0, or class 7 with N_CLASSES = 7 -> exc_req_o stays 0, viol_cnt_o = 0.
- In REQ, hold exc_ack_i = 0 for 5 cycles while driving new hits -> exc_req_o held 5 cycles, count unchanged; ack -> exc_req_o = 0 next cycle; a hit in that cycle -> exc_req_o = 1 again, count = 2.
- CNT_WIDTH = 2, four violations each acked -> viol_cnt_o = 3 after third and fourth; clear_i together with a fifth hit -> viol_cnt_o = 1.
- rst asserted mid-REQ -> next cycle exc_req_o = 0, stall_o = 0, all status 0; hit after reset released -> normal 1-cycle request.
- Macro defined: tcr bit 24 = 1, tag_pc_i = 1, class 2 with S1/S2/D enables clear -> exc_req_o = 1, viol_src_o = 4'b1000; macro undefined -> no request.
